// File: rtl/axi_rom_rd_arb.sv
// Two-master round-robin arbiter for the boot ROM read-only AXI subset (AR + R channels).
// Optional data-phase watchdog is built when AXI_ROM_ARB_TIMEOUT_EN is defined.
module axi_rom_rd_arb #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_W           = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    input  logic [31:0] m0_ar,
    input  logic [7:0]  m0_arlen,
    input  logic [1:0]  m0_arburst,
    output logic [31:0] m0_r,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    output logic        m0_rlast,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    input  logic [31:0] m1_ar,
    input  logic [7:0]  m1_arlen,
    input  logic [1:0]  m1_arburst,
    output logic [31:0] m1_r,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    output logic        m1_rlast,
    output logic        s_arvalid,
    input  logic        s_arready,
    output logic [31:0] s_ar,
    output logic [7:0]  s_arlen,
    output logic [1:0]  s_arburst,
    input  logic [31:0] s_r,
    input  logic        s_rvalid,
    output logic        s_rready,
    input  logic        s_rlast,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    if (TO_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_bad_to_w
        $error("TO_W too narrow to hold TIMEOUT_CYCLES");
    end

    state_t     state, state_nx;
    logic [1:0] grant_q, grant_nx;
    logic [1:0] last_q, last_nx;
    logic [8:0] beat_q, beat_nx;

    logic in_addr, in_data;
    logic g_arvalid, g_rready;
    logic ar_hs, r_hs, done;
    logic wd_fire;

    assign in_addr   = (state == ADDR);
    assign in_data   = (state == DATA);
    assign g_arvalid = grant_q[1] ? m1_arvalid : m0_arvalid;
    assign g_rready  = grant_q[1] ? m1_rready  : m0_rready;
    assign ar_hs     = in_addr & g_arvalid & s_arready;
    assign r_hs      = in_data & s_rvalid & g_rready;
    assign done      = r_hs & s_rlast;

    // Round-robin pointer (last_q) moves only when a transaction ends.
    always_comb begin
        state_nx = state;
        grant_nx = grant_q;
        last_nx  = last_q;
        beat_nx  = beat_q;
        case (state)
            IDLE: begin
                if (m0_arvalid && m1_arvalid) begin
                    grant_nx = last_q[1] ? 2'b01 : 2'b10;
                    state_nx = ADDR;
                end else if (m0_arvalid) begin
                    grant_nx = 2'b01;
                    state_nx = ADDR;
                end else if (m1_arvalid) begin
                    grant_nx = 2'b10;
                    state_nx = ADDR;
                end
            end
            ADDR: begin
                if (ar_hs) begin
                    state_nx = DATA;
                    beat_nx  = '0;
                end
            end
            DATA: begin
                if (r_hs) beat_nx = beat_q + 9'd1;
                if (done || wd_fire) begin
                    state_nx = IDLE;
                    last_nx  = grant_q;
                    grant_nx = 2'b00;
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 2'b10;
            beat_q  <= '0;
        end else begin
            state   <= state_nx;
            grant_q <= grant_nx;
            last_q  <= last_nx;
            beat_q  <= beat_nx;
        end
    end

`ifdef AXI_ROM_ARB_TIMEOUT_EN
    logic [TO_W-1:0] wd_q, wd_nx;
    logic            terr_q, terr_nx;

    assign wd_fire = in_data && !done && (wd_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_nx   = wd_q;
        terr_nx = terr_q;
        if (ar_hs) begin
            wd_nx = '0;
        end else if (in_data && !done) begin
            if (wd_fire) terr_nx = 1'b1;
            else         wd_nx   = wd_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q   <= '0;
            terr_q <= 1'b0;
        end else begin
            wd_q   <= wd_nx;
            terr_q <= terr_nx;
        end
    end

    assign timeout_err = terr_q;
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Address channel is only driven toward the ROM while in ADDR.
    assign s_arvalid  = in_addr & g_arvalid;
    assign s_ar       = in_addr ? (grant_q[1] ? m1_ar      : m0_ar)      : 32'd0;
    assign s_arlen    = in_addr ? (grant_q[1] ? m1_arlen   : m0_arlen)   : 8'd0;
    assign s_arburst  = in_addr ? (grant_q[1] ? m1_arburst : m0_arburst) : 2'd0;
    assign m0_arready = in_addr & grant_q[0] & s_arready;
    assign m1_arready = in_addr & grant_q[1] & s_arready;

    assign s_rready   = in_data & g_rready;
    assign m0_rvalid  = in_data & grant_q[0] & s_rvalid;
    assign m1_rvalid  = in_data & grant_q[1] & s_rvalid;
    assign m0_rlast   = in_data & grant_q[0] & s_rlast;
    assign m1_rlast   = in_data & grant_q[1] & s_rlast;
    assign m0_r       = s_r;
    assign m1_r       = s_r;

    assign grant = grant_q;
    assign busy  = (state != IDLE);

    // A compliant ROM ends every burst by its 256th beat.
    beat_bound: assert property (@(posedge clk) disable iff (rst)
        (in_data && s_rvalid && s_rready && s_rlast) |-> (beat_q <= 9'd255));

endmodule
